// File: rtl/red_pitaya_dac_soft_pkg.sv
// Shared types and constants for the DAC soft-start/soft-stop output stage.
package red_pitaya_dac_soft_pkg;

    localparam int DW_DEF = 14;
    localparam int GW_DEF = 16;
    localparam int PW_DEF = DW_DEF + GW_DEF + 2;

    localparam logic [GW_DEF:0] GAIN_ONE = {1'b1, {GW_DEF{1'b0}}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

endpackage

// File: rtl/red_pitaya_slew_lim.sv
// Per-sample slew limiter: clamps the step from the previous output to +/-slew.
module red_pitaya_slew_lim #(
    parameter int DW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x,
    input  logic        [DW-1:0] slew,
    output logic signed [DW-1:0] y
);

    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] L_SMAX = EW'((2 ** (DW - 1)) - 1);
    localparam logic signed [EW-1:0] L_SMIN = ~L_SMAX;

    logic signed [DW-1:0] r_y;
    logic signed [EW-1:0] w_x;
    logic signed [EW-1:0] w_prev;
    logic signed [EW-1:0] w_slew;
    logic signed [EW-1:0] w_lo;
    logic signed [EW-1:0] w_hi;
    logic signed [EW-1:0] w_clamp;
    logic signed [DW-1:0] w_y_next;

    assign w_x    = EW'(x);
    assign w_prev = EW'(r_y);
    assign w_slew = $signed({2'b00, slew});
    assign w_lo   = w_prev - w_slew;
    assign w_hi   = w_prev + w_slew;

    always_comb begin
        w_clamp = w_x;
        if (slew != '0) begin
            if (w_x < w_lo) begin
                w_clamp = w_lo;
            end else if (w_x > w_hi) begin
                w_clamp = w_hi;
            end
        end
        w_y_next = w_clamp[DW-1:0];
        if (w_clamp > L_SMAX) begin
            w_y_next = L_SMAX[DW-1:0];
        end else if (w_clamp < L_SMIN) begin
            w_y_next = L_SMIN[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_next;
        end
    end

    assign y = r_y;

endmodule

// File: rtl/red_pitaya_dac_soft_out.sv
// DAC output conditioning: gain ramp on enable/disable, slew limit, output format.
module red_pitaya_dac_soft_out
    import red_pitaya_dac_soft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int GW = GW_DEF
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          en_i,
    input  logic [GW-1:0] ramp_step_i,
    input  logic [DW-1:0] slew_i,
    input  logic          fmt_ob_i,
    output logic [DW-1:0] dac_o,
    output logic [1:0]    state_o,
    output logic          ramp_done_o
);

    localparam int PW = DW + GW + 2;
    localparam logic [GW:0] L_ONE = {1'b1, {GW{1'b0}}};
    localparam logic signed [PW-1:0] L_SMAX = PW'((2 ** (DW - 1)) - 1);
    localparam logic signed [PW-1:0] L_SMIN = ~L_SMAX;

    state_t               r_state;
    logic [GW:0]          r_gain;
    logic                 r_done;
    logic signed [PW-1:0] r_prod;
    logic signed [DW-1:0] r_scaled;

    logic [GW+1:0]        w_gain_inc;
    logic [GW:0]          w_gain_dec;
    logic                 w_up_full;
    logic                 w_down_empty;
    logic                 w_step_zero;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic signed [DW-1:0] w_scaled;
    logic signed [DW-1:0] w_y;

    assign w_gain_inc   = {1'b0, r_gain} + {2'b00, ramp_step_i};
    assign w_gain_dec   = r_gain - {1'b0, ramp_step_i};
    assign w_up_full    = (w_gain_inc >= {1'b0, L_ONE});
    assign w_down_empty = ({1'b0, ramp_step_i} >= r_gain);
    assign w_step_zero  = (ramp_step_i == '0);

    // Direction reversals only change state; the gain resumes moving from
    // where it was on the following cycle. Ramp completion beats en_i.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            r_state <= ST_OFF;
            r_gain  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    r_gain <= '0;
                    if (en_i) begin
                        if (w_step_zero) begin
                            r_state <= ST_ON;
                            r_gain  <= L_ONE;
                        end else begin
                            r_state <= ST_UP;
                        end
                    end
                end
                ST_UP: begin
                    if (w_up_full) begin
                        r_state <= ST_ON;
                        r_gain  <= L_ONE;
                        r_done  <= 1'b1;
                    end else if (!en_i) begin
                        r_state <= ST_DOWN;
                    end else begin
                        r_gain <= w_gain_inc[GW:0];
                    end
                end
                ST_ON: begin
                    r_gain <= L_ONE;
                    if (!en_i) begin
                        if (w_step_zero) begin
                            r_state <= ST_OFF;
                            r_gain  <= '0;
                        end else begin
                            r_state <= ST_DOWN;
                        end
                    end
                end
                ST_DOWN: begin
                    if (w_down_empty) begin
                        r_state <= ST_OFF;
                        r_gain  <= '0;
                        r_done  <= 1'b1;
                    end else if (en_i) begin
                        r_state <= ST_UP;
                    end else begin
                        r_gain <= w_gain_dec;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_gain  <= '0;
                end
            endcase
        end
    end

    assign w_prod  = PW'($signed(dat_i)) * PW'($signed({1'b0, r_gain}));
    assign w_shift = r_prod >>> GW;

    always_comb begin
        w_scaled = w_shift[DW-1:0];
        if (w_shift > L_SMAX) begin
            w_scaled = L_SMAX[DW-1:0];
        end else if (w_shift < L_SMIN) begin
            w_scaled = L_SMIN[DW-1:0];
        end
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            r_prod   <= '0;
            r_scaled <= '0;
        end else begin
            r_prod   <= w_prod;
            r_scaled <= w_scaled;
        end
    end

    red_pitaya_slew_lim #(
        .DW (DW)
    ) u_slew_lim (
        .clk  (dac_clk_i),
        .rst  (dac_rst_i),
        .x    (r_scaled),
        .slew (slew_i),
        .y    (w_y)
    );

    assign dac_o       = fmt_ob_i ? {~w_y[DW-1], w_y[DW-2:0]} : w_y;
    assign state_o     = r_state;
    assign ramp_done_o = r_done;

endmodule
